// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath/memory width defaults and the
// program loader state encoding.
package riscv_pkg;

    localparam int unsigned CPU_WIDTH_DEF   = 32;
    localparam int unsigned IMEM_ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_RECV  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/instr_word_assembler.sv
// Packs a little-endian byte stream into instruction words; word/word_valid
// are registered so they line up with the loader's write cycle.
module instr_word_assembler
    import riscv_pkg::*;
#(
    parameter int unsigned CPU_WIDTH = CPU_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 byte_en,
    input  logic [7:0]           byte_data,
    output logic                 word_last,
    output logic [CPU_WIDTH-1:0] word,
    output logic                 word_valid
);

    logic [1:0]           byte_cnt;
    logic [CPU_WIDTH-1:0] shreg;
    logic [CPU_WIDTH-1:0] shifted;

    // Newest byte enters at the top, so after four shifts the first byte sits in [7:0].
    assign shifted   = {byte_data, shreg[CPU_WIDTH-1:8]};
    assign word_last = byte_en && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            shreg      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_last;
            if (clear) begin
                byte_cnt <= '0;
                shreg    <= '0;
            end else if (byte_en) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= shifted;
                if (word_last) begin
                    word <= shifted;
                end
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Streams a program from a byte source into instruction memory while holding
// the core in reset; pulses done when the requested word count is written.
module instr_loader
    import riscv_pkg::*;
#(
    parameter int unsigned CPU_WIDTH   = CPU_WIDTH_DEF,
    parameter int unsigned IMEM_ADDR_W = IMEM_ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IMEM_ADDR_W:0]   len,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [CPU_WIDTH-1:0]   imem_wdata,
    output logic                   core_hold,
    output logic                   done
);

    localparam logic [IMEM_ADDR_W:0] DEPTH = {1'b1, {IMEM_ADDR_W{1'b0}}};
    localparam logic [IMEM_ADDR_W:0] ONE   = {{IMEM_ADDR_W{1'b0}}, 1'b1};

    loader_state_t          state, state_next;
    logic [IMEM_ADDR_W:0]   len_q;
    logic [IMEM_ADDR_W:0]   written;
    logic [IMEM_ADDR_W-1:0] addr;
    logic                   clear;
    logic                   word_last;
    logic                   word_valid;

    instr_word_assembler #(
        .CPU_WIDTH (CPU_WIDTH)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .byte_en    (byte_valid && byte_ready),
        .byte_data  (byte_data),
        .word_last  (word_last),
        .word       (imem_wdata),
        .word_valid (word_valid)
    );

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        unique case (state)
            LD_IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = (len == '0) ? LD_DONE : LD_RECV;
                end
            end
            LD_RECV: begin
                if (word_last) state_next = LD_WRITE;
            end
            // Completion uses the written count, not the address, so the
            // address wrap at full depth cannot end or extend the load.
            LD_WRITE: state_next = ((written + ONE) == len_q) ? LD_DONE : LD_RECV;
            LD_DONE:  state_next = LD_IDLE;
            default:  state_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LD_IDLE;
            len_q   <= '0;
            written <= '0;
            addr    <= '0;
        end else begin
            state <= state_next;
            if (state == LD_IDLE && start) begin
                len_q   <= (len > DEPTH) ? DEPTH : len;
                written <= '0;
                addr    <= '0;
            end else if (state == LD_WRITE) begin
                written <= written + ONE;
                addr    <= addr + 1'b1;
            end
        end
    end

    assign byte_ready = (state == LD_RECV);
    assign imem_we    = (state == LD_WRITE) && word_valid;
    assign imem_addr  = addr;
    assign core_hold  = (state == LD_RECV) || (state == LD_WRITE);
    assign done       = (state == LD_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Directed and randomized program loads checked against a word-list reference
// built from the byte stream with plain little-endian arithmetic.
module tb_instr_loader;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          done;

    int unsigned passes = 0;
    int unsigned total  = 0;

    // Monitor state: cumulative, only ever written by the monitor process.
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    int unsigned   done_cnt  = 0;
    int unsigned   overlap   = 0;
    int unsigned   hold_bad  = 0;
    int unsigned   stab_bad  = 0;
    logic [31:0]   prev_wdata = '0;

    byte unsigned  fixed_q[$];

    instr_loader #(
        .CPU_WIDTH   (32),
        .IMEM_ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                obs_addr.push_back(imem_addr);
                obs_data.push_back(imem_wdata);
            end
            if (done) done_cnt++;
            if (imem_we && byte_ready) overlap++;
            if (done && core_hold) hold_bad++;
            if (!imem_we && imem_wdata !== prev_wdata) stab_bad++;
        end
        prev_wdata = imem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Runs one load starting on a negedge and returns on a negedge.
    task automatic do_load(input int unsigned len_in, input bit toggle, input bit restart,
                           input string tag);
        int unsigned  nw, nb, idx, cyc, bound, bad, w0, d0, o0, h0, s0, nobs;
        byte unsigned bq[$];
        logic [31:0]  exp_w[$];
        bit           tog;

        nw = (len_in > DEPTH) ? DEPTH : len_in;
        nb = nw * 4;
        for (int i = 0; i < int'(nb); i++)
            bq.push_back((i < fixed_q.size()) ? fixed_q[i] : 8'($urandom));
        for (int w = 0; w < int'(nw); w++)
            exp_w.push_back({bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]});

        w0 = obs_addr.size(); d0 = done_cnt; o0 = overlap; h0 = hold_bad; s0 = stab_bad;

        start = 1'b1;
        len   = (AW+1)'(len_in);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_hold_after_start"}, 64'(core_hold), 64'(nw != 0));
        if (nw == 0) begin
            check({tag, "_done_next_cycle"}, 64'(done), 64'd1);
            check({tag, "_ready_low"}, 64'(byte_ready), 64'd0);
        end

        idx = 0; cyc = 0; tog = 1'b0; bound = nb * 8 + 64;
        while (idx < nb && cyc < bound) begin
            tog        = !tog;
            byte_valid = toggle ? tog : ($urandom_range(0, 3) != 0);
            byte_data  = bq[idx];
            if (restart && cyc == 3) begin
                start = 1'b1;
                len   = (AW+1)'(5);
            end else begin
                start = 1'b0;
            end
            if (byte_valid && byte_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        check({tag, "_bytes_sent"}, 64'(idx), 64'(nb));

        cyc = 0;
        while (done_cnt == d0 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);

        nobs = obs_addr.size() - w0;
        check({tag, "_write_count"}, 64'(nobs), 64'(nw));
        bad = 0;
        for (int i = 0; i < int'(nobs) && i < int'(nw); i++) begin
            if (obs_addr[w0+i] !== AW'(i % DEPTH)) bad++;
            if (obs_data[w0+i] !== exp_w[i]) bad++;
        end
        if (nw > 0) check({tag, "_first_word"}, 64'(obs_data[w0]), 64'(exp_w[0]));
        check({tag, "_addr_data_errors"}, 64'(bad), 64'd0);
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_ready_during_write"}, 64'(overlap - o0), 64'd0);
        check({tag, "_hold_at_done"}, 64'(hold_bad - h0), 64'd0);
        check({tag, "_wdata_stable"}, 64'(stab_bad - s0), 64'd0);
        check({tag, "_idle_hold"}, 64'(core_hold), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, "_core_hold"}, 64'(core_hold), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int unsigned w0, d0;

        rst = 1'b1; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        fixed_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_load(2, 1'b0, 1'b0, "len2");
        check("len2_word1", 64'(obs_data[obs_data.size()-1]), 64'h0010_0093);
        fixed_q.delete();

        do_load(0, 1'b0, 1'b0, "len0");
        do_load(1, 1'b1, 1'b0, "len1_toggle");

        // Abandon a load after two bytes of the first word.
        w0 = obs_addr.size(); d0 = done_cnt;
        start = 1'b1; len = (AW+1)'(1);
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b1; byte_data = 8'hAA;
        @(negedge clk);
        byte_data = 8'hBB;
        @(negedge clk);
        byte_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midload_rst");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midload_no_write", 64'(obs_addr.size() - w0), 64'd0);
        check("midload_no_done", 64'(done_cnt - d0), 64'd0);

        do_load(1, 1'b0, 1'b0, "after_rst");
        do_load(1, 1'b0, 1'b1, "restart_ignored");
        do_load(3, 1'b0, 1'b0, "rand3");
        do_load(DEPTH + 5, 1'b0, 1'b0, "clamp");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
